// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared alarm-setting types, BCD limits and default alarm time
package clock_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10
  } mode_t;

  localparam logic [7:0] HOUR_MAX = 8'h23;
  localparam logic [7:0] MIN_MAX  = 8'h59;
  localparam logic [7:0] DEF_HOUR = 8'h07;
  localparam logic [7:0] DEF_MIN  = 8'h00;

endpackage

// File: rtl/alarm_set_if.sv
// rtl/alarm_set_if.sv - key, tick and time signals between the keypad/clock side and alarm_set
interface alarm_set_if;
  logic       tick;
  logic       key_mode;
  logic       key_inc;
  logic       key_stop;
  logic [7:0] hour1;
  logic [7:0] min1;
  logic [7:0] ahour;
  logic [7:0] amin;
  logic       clcok_stop;
  logic [1:0] set_mode;

  modport master (
    output tick, key_mode, key_inc, key_stop, hour1, min1,
    input  ahour, amin, clcok_stop, set_mode
  );

  modport slave (
    input  tick, key_mode, key_inc, key_stop, hour1, min1,
    output ahour, amin, clcok_stop, set_mode
  );
endinterface

// File: rtl/bcd_inc_wrap.sv
// rtl/bcd_inc_wrap.sv - combinational two-digit BCD increment, wrapping to 00 after max
module bcd_inc_wrap (
  input  logic [7:0] value,
  input  logic [7:0] max,
  output logic [7:0] result
);
  always_comb begin
    if (value == max) begin
      result = 8'h00;
    end else if (value[3:0] == 4'h9) begin
      result = {value[7:4] + 4'd1, 4'h0};
    end else begin
      result = {value[7:4], value[3:0] + 4'd1};
    end
  end
endmodule

// File: rtl/alarm_set.sv
// rtl/alarm_set.sv - alarm time setting FSM with auto-repeat, arm/disarm and silencing
module alarm_set
  import clock_pkg::*;
#(
  parameter logic [7:0] RST_HOUR     = DEF_HOUR,
  parameter logic [7:0] RST_MIN      = DEF_MIN,
  parameter int         REPEAT_DELAY = 5,
  parameter int         REPEAT_RATE  = 2
) (
  input logic       clk,
  input logic       rst_n,
  alarm_set_if.slave bus
);
  localparam int CW = $clog2(REPEAT_DELAY + 1);

  mode_t         state, state_nx;
  logic [7:0]    ahour_r, amin_r, ahour_nx, amin_nx, hour_inc, min_inc;
  logic          alarm_on, alarm_on_nx, silenced, silenced_nx, stop_r;
  logic [CW-1:0] rep_cnt, rep_cnt_nx;
  logic          mode_q, inc_q, stop_q, armed;
  logic          mode_rise, inc_rise, stop_rise, match, rep_fire, inc_evt;

  // armed masks edges on the first cycle after reset so a key held through reset is not a press
  assign mode_rise = bus.key_mode & ~mode_q & armed;
  assign inc_rise  = bus.key_inc  & ~inc_q  & armed;
  assign stop_rise = bus.key_stop & ~stop_q & armed;
  assign match     = (bus.hour1 == ahour_r) && (bus.min1 == amin_r);

  bcd_inc_wrap u_hour_inc (.value(ahour_r), .max(HOUR_MAX), .result(hour_inc));
  bcd_inc_wrap u_min_inc  (.value(amin_r),  .max(MIN_MAX),  .result(min_inc));

  always_comb begin
    state_nx    = state;
    ahour_nx    = ahour_r;
    amin_nx     = amin_r;
    alarm_on_nx = alarm_on;
    silenced_nx = silenced & match;
    rep_cnt_nx  = '0;
    rep_fire    = 1'b0;
    inc_evt     = 1'b0;

    // after the first repeat the counter restarts RATE ticks short of DELAY
    if (bus.key_inc && state != IDLE && !mode_rise) begin
      rep_cnt_nx = rep_cnt;
      if (bus.tick) begin
        if (int'(rep_cnt) + 1 == REPEAT_DELAY) begin
          rep_fire   = 1'b1;
          rep_cnt_nx = CW'(REPEAT_DELAY - REPEAT_RATE);
        end else begin
          rep_cnt_nx = rep_cnt + CW'(1);
        end
      end
    end
    inc_evt = (inc_rise && !mode_rise) || rep_fire;

    case (state)
      IDLE: begin
        if (mode_rise) state_nx = SET_HOUR;
        if (stop_rise) begin
          if (match && alarm_on && !silenced) silenced_nx = 1'b1;
          else                                alarm_on_nx = !alarm_on;
        end
      end
      SET_HOUR: begin
        if (mode_rise) begin
          state_nx = SET_MIN;
        end else if (inc_evt) begin
          ahour_nx    = hour_inc;
          silenced_nx = 1'b0;
        end
      end
      SET_MIN: begin
        if (mode_rise) begin
          state_nx = IDLE;
        end else if (inc_evt) begin
          amin_nx     = min_inc;
          silenced_nx = 1'b0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ahour_r  <= RST_HOUR;
      amin_r   <= RST_MIN;
      alarm_on <= 1'b0;
      silenced <= 1'b0;
      stop_r   <= 1'b1;
      rep_cnt  <= '0;
      mode_q   <= 1'b0;
      inc_q    <= 1'b0;
      stop_q   <= 1'b0;
      armed    <= 1'b0;
    end else begin
      state    <= state_nx;
      ahour_r  <= ahour_nx;
      amin_r   <= amin_nx;
      alarm_on <= alarm_on_nx;
      silenced <= silenced_nx;
      stop_r   <= !alarm_on_nx | silenced_nx | (state_nx != IDLE);
      rep_cnt  <= rep_cnt_nx;
      mode_q   <= bus.key_mode;
      inc_q    <= bus.key_inc;
      stop_q   <= bus.key_stop;
      armed    <= 1'b1;
    end
  end

  assign bus.ahour      = ahour_r;
  assign bus.amin       = amin_r;
  assign bus.clcok_stop = stop_r;
  assign bus.set_mode   = state;
endmodule
